pcie_dllp_crc_engine: RTL and testbench
=======================================

// Module: pcie_dllp_crc_engine
// PURPOSE
//  Parametrised DLLP CRC-16 engine for the PCIe data link layer. It accumulates the 4 DLLP
//  content bytes over one or more beats, then presents the full 6-byte DLLP.
//  gen mode: the computed CRC is appended. chk mode: the received CRC is compared.
//  Sits between the DLLP scheduler/receiver and the framing logic; one-entry output buffer.
// PARAMETERS
//  BPB   1  bytes per input beat; legal values 1, 2, 4 (4/BPB beats per DLLP)
//  SEED  16'hFFFF  CRC seed loaded at each DLLP start
// PORTS
//  clk          in   1        single clock
//  reset        in   1        asynchronous, active-low reset
//  chk_mode     in   1        0 = generate, 1 = check; sampled on first beat of a DLLP
//  s_valid      in   1        input beat valid
//  s_ready      out  1        input beat accepted when s_valid & s_ready
//  s_sop        in   1        first beat of a DLLP
//  s_data       in   8*BPB    content bytes; byte0 in [7:0], earliest on wire
//  s_crc        in   16       received CRC bytes {byte4,byte5}; sampled on last beat (chk)
//  m_valid      out  1        result valid
//  m_ready      in   1        result consumed when m_valid & m_ready
//  m_dllp       out  48       {byte0..byte5}, byte0 in [47:40]
//  m_crc_err    out  1        chk: computed != s_crc; gen: always 0
//  abort        out  1        1-cycle pulse: partial DLLP discarded by early s_sop
// BEHAVIOUR
//  - CRC: poly x^16+x^12+x^3+x+1 (0x100B), seeded with SEED. Bytes are processed byte0 first,
//    each byte LSB first. The final value is F = ~C. byte4[i] = F[15-i], byte5[i] = F[7-i].
//  - Per-beat update: a combinational 8*BPB-bit-parallel next-state function on a 16-bit
//    register; one beat per clk.
//  - FSM: IDLE (cnt=0) -> ACC (partial) -> HOLD (m_valid=1).
//    IDLE->ACC or ->HOLD on an accepted s_sop beat (->HOLD directly when BPB=4).
//    ACC->HOLD on the accepted beat that completes 4 bytes. HOLD->IDLE on m_ready.
//  - Beats without s_sop in IDLE are dropped; s_ready=1 for them.
//  - s_sop in ACC: partial discarded, abort=1 for 1 cycle, CRC reseeded, new DLLP begins.
//  - Latency: m_valid rises the cycle after the last content beat is accepted.
//  - s_ready = !m_valid | m_ready.
//  - Simultaneous drain and new last beat: m_ready & m_valid with a final beat in the same
//    cycle loads the new result with no bubble; m_valid stays 1.
//  - m_dllp/m_crc_err stable while m_valid & !m_ready.
//  - chk_mode latched at sop; changes mid-DLLP are ignored.
//  - Reset (any time, incl. mid-DLLP): state IDLE, CRC=SEED, cnt=0, m_valid=0,
//    m_dllp=0, m_crc_err=0, abort=0, err_cnt=0.
// CONFIGURATION
//  DLLP_CRC_STATS_EN defined: adds output err_cnt [15:0].
//    Increments when a chk-mode result with m_crc_err=1 is consumed; saturates at 16'hFFFF.
//    Clears only on reset.
//  DLLP_CRC_STATS_EN undefined: no err_cnt port and no counter logic; all else identical.
// TESTING
//  1 gen, BPB=1, bytes 00 00 00 00 -> m_dllp[47:16]=0 and CRC equal to the bench bit-serial
//    model; m_valid 1 cycle after the 4th beat.
//  2 loopback: gen output 0x0000_0001+CRC fed to chk -> m_crc_err=0;
//    flip s_crc bit 0 -> m_crc_err=1.
//  3 BPB=2,4 with content 0xA5_00_0F_3C -> CRC identical to the BPB=1 run.
//  4 s_sop after 2 of 4 bytes (BPB=1) -> abort pulse; new DLLP result correct; old bytes absent.
//  5 m_ready=0 for 5 cycles with a second DLLP queued -> s_ready=0 on its last beat,
//    m_dllp held; m_ready=1 then second result back-to-back, no bubble.
//  6 reset low mid-DLLP then a fresh DLLP -> outputs 0 during reset; result matches model;
//    with STATS_EN, 3 bad chk DLLPs -> err_cnt=3.

Source files
------------

// File: rtl/pcie_dllp_crc_engine.sv
// pcie_dllp_crc_engine
//   DLLP CRC-16 engine. Collects the four DLLP content bytes over 4/BPB
//   beats, then presents the 6-byte DLLP in a one-entry output buffer.
//   Generate mode appends the computed CRC. Check mode compares the
//   computed CRC against the received one.
//   Optional build macro: DLLP_CRC_STATS_EN adds err_cnt_o, a saturating
//   count of consumed check-mode results that carry a CRC error.
//   BPB must be 1, 2 or 4.
module pcie_dllp_crc_engine #(
  parameter int          BPB  = 1,
  parameter logic [15:0] SEED = 16'hFFFF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             chk_mode_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic             s_sop_i,
  input  logic [8*BPB-1:0] s_data_i,
  input  logic [15:0]      s_crc_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [47:0]      m_dllp_o,
  output logic             m_crc_err_o,
  output logic             abort_o
`ifdef DLLP_CRC_STATS_EN
  ,
  output logic [15:0]      err_cnt_o
`endif
);

  localparam int BEATS = 4 / BPB;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [15:0]     crc_q, crc_d;
  logic            chk_q, chk_d;
  logic [3:0][7:0] bytes_q, bytes_d;   // byte0 sits in bytes_q[3]
  logic [47:0]     dllp_q, dllp_d;
  logic            err_q, err_d;
  logic            abort_q, abort_d;

  logic            accept, start, take, last, chk_cur;
  logic [1:0]      base_cnt;
  logic [15:0]     base_crc, crc_next, crc_fin, crc_calc;
  logic [7:0]      crc_b4, crc_b5;

  // Bit-parallel CRC over one beat: byte0 first, each byte LSB first.
  function automatic logic [15:0] crc_step(input logic [15:0] c,
                                           input logic [8*BPB-1:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8 * BPB; i++) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h100B;
    end
    return r;
  endfunction

  // A result is held only when no partial DLLP exists, so m_valid maps to HOLD.
  assign m_valid_o = (state_q == HOLD);
  assign s_ready_o = !m_valid_o || m_ready_i;
  assign accept    = s_valid_i && s_ready_o;
  assign start     = accept && s_sop_i;
  // Non-sop beats outside ACC are accepted but ignored.
  assign take      = start || (accept && (state_q == ACC));
  assign base_cnt  = start ? 2'd0 : cnt_q;
  assign base_crc  = start ? SEED : crc_q;
  assign chk_cur   = start ? chk_mode_i : chk_q;
  assign last      = (base_cnt == 2'(BEATS - 1));
  assign crc_next  = crc_step(base_crc, s_data_i);
  assign crc_fin   = ~crc_next;

  // Wire order: byte4 carries F[15:8] and byte5 F[7:0], each bit-reversed.
  for (genvar gi = 0; gi < 8; gi++) begin : g_crc_bytes
    assign crc_b4[gi] = crc_fin[15-gi];
    assign crc_b5[gi] = crc_fin[7-gi];
  end
  assign crc_calc = {crc_b4, crc_b5};

  // Next-state: accumulate beats, load the output buffer on the final beat.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    chk_d   = chk_q;
    bytes_d = bytes_q;
    dllp_d  = dllp_q;
    err_d   = err_q;
    abort_d = start && (state_q == ACC);
    if (m_valid_o && m_ready_i) state_d = IDLE;
    if (take) begin
      for (int j = 0; j < BPB; j++) begin
        bytes_d[2'(3 - int'(base_cnt) * BPB - j)] = s_data_i[8*j +: 8];
      end
      chk_d = chk_cur;
      if (last) begin
        state_d = HOLD;
        cnt_d   = 2'd0;
        crc_d   = SEED;
        dllp_d  = {bytes_d, (chk_cur ? s_crc_i : crc_calc)};
        err_d   = chk_cur && (crc_calc != s_crc_i);
      end else begin
        state_d = ACC;
        cnt_d   = base_cnt + 2'd1;
        crc_d   = crc_next;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      crc_q   <= SEED;
      chk_q   <= 1'b0;
      bytes_q <= '0;
      dllp_q  <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      chk_q   <= chk_d;
      bytes_q <= bytes_d;
      dllp_q  <= dllp_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign m_dllp_o    = dllp_q;
  assign m_crc_err_o = err_q;
  assign abort_o     = abort_q;

`ifdef DLLP_CRC_STATS_EN
  logic [15:0] err_cnt_q;

  // Count consumed results flagged bad; err_q is only ever set in check mode.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= 16'd0;
    end else if (m_valid_o && m_ready_i && err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_pcie_dllp_crc_engine.sv
// tb_pcie_dllp_crc_engine
//   Directed bench for pcie_dllp_crc_engine with BPB = 1, 2 and 4 instances.
//   Expected CRCs come from a bit-serial reference model.
//   Build with DLLP_CRC_STATS_EN to also exercise err_cnt_o.
module tb_pcie_dllp_crc_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        chk_mode = 1'b0;
  logic        m_ready = 1'b1;
  logic [15:0] s_crc = 16'h0;

  logic        v1 = 1'b0, sop1 = 1'b0;
  logic [7:0]  d1 = '0;
  logic        v2 = 1'b0, sop2 = 1'b0;
  logic [15:0] d2 = '0;
  logic        v4 = 1'b0, sop4 = 1'b0;
  logic [31:0] d4 = '0;

  logic        rdy1, mv1, er1, ab1;
  logic        rdy2, mv2, er2, ab2;
  logic        rdy4, mv4, er4, ab4;
  logic [47:0] dl1, dl2, dl4;
`ifdef DLLP_CRC_STATS_EN
  logic [15:0] ec1, ec2, ec4;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pcie_dllp_crc_engine #(.BPB(1)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .chk_mode_i(chk_mode),
    .s_valid_i(v1), .s_ready_o(rdy1), .s_sop_i(sop1), .s_data_i(d1), .s_crc_i(s_crc),
    .m_valid_o(mv1), .m_ready_i(m_ready), .m_dllp_o(dl1), .m_crc_err_o(er1), .abort_o(ab1)
`ifdef DLLP_CRC_STATS_EN
    , .err_cnt_o(ec1)
`endif
  );

  pcie_dllp_crc_engine #(.BPB(2)) u2 (
    .clk_i(clk), .rst_ni(rst_n), .chk_mode_i(chk_mode),
    .s_valid_i(v2), .s_ready_o(rdy2), .s_sop_i(sop2), .s_data_i(d2), .s_crc_i(s_crc),
    .m_valid_o(mv2), .m_ready_i(m_ready), .m_dllp_o(dl2), .m_crc_err_o(er2), .abort_o(ab2)
`ifdef DLLP_CRC_STATS_EN
    , .err_cnt_o(ec2)
`endif
  );

  pcie_dllp_crc_engine #(.BPB(4)) u4 (
    .clk_i(clk), .rst_ni(rst_n), .chk_mode_i(chk_mode),
    .s_valid_i(v4), .s_ready_o(rdy4), .s_sop_i(sop4), .s_data_i(d4), .s_crc_i(s_crc),
    .m_valid_o(mv4), .m_ready_i(m_ready), .m_dllp_o(dl4), .m_crc_err_o(er4), .abort_o(ab4)
`ifdef DLLP_CRC_STATS_EN
    , .err_cnt_o(ec4)
`endif
  );

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Reference: shift the 32 content bits one at a time, byte0 first, LSB first.
  function automatic logic [15:0] crc_model(input logic [31:0] content);
    logic [15:0] c;
    logic [15:0] f;
    logic [7:0]  b, b4, b5;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      b = content[31-8*k -: 8];
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ b[i];
        c  = c << 1;
        if (fb) c = c ^ 16'h100B;
      end
    end
    f = ~c;
    for (int i = 0; i < 8; i++) begin
      b4[i] = f[15-i];
      b5[i] = f[7-i];
    end
    return {b4, b5};
  endfunction

  function automatic logic ready_of(input int inst);
    case (inst)
      1:       return rdy1;
      2:       return rdy2;
      default: return rdy4;
    endcase
  endfunction

  // One input beat; waits (bounded) for s_ready, returns 1 time unit after the accepting edge.
  task automatic beat(input int inst, input logic sop, input logic [31:0] d, input logic [15:0] crc);
    int   w;
    logic r;
    w = 0;
    s_crc = crc;
    case (inst)
      1:       begin v1 = 1'b1; sop1 = sop; d1 = d[7:0];  end
      2:       begin v2 = 1'b1; sop2 = sop; d2 = d[15:0]; end
      default: begin v4 = 1'b1; sop4 = sop; d4 = d;       end
    endcase
    #1;
    r = ready_of(inst);
    while (!r && w < 50) begin
      @(posedge clk); #1;
      w++;
      r = ready_of(inst);
    end
    if (!r) check_eq("ready_wait", {47'd0, r}, 48'd1);
    @(posedge clk); #1;
    v1 = 1'b0; v2 = 1'b0; v4 = 1'b0;
    sop1 = 1'b0; sop2 = 1'b0; sop4 = 1'b0;
  endtask

  // Whole DLLP; chk_mode flips after the first beat to confirm it is latched at sop.
  task automatic send_dllp(input int inst, input logic chk, input logic [31:0] content,
                           input logic [15:0] crc);
    logic [31:0] bd;
    int          nb;
    nb = 4 / inst;
    chk_mode = chk;
    for (int b = 0; b < nb; b++) begin
      bd = '0;
      for (int j = 0; j < inst; j++) bd[8*j +: 8] = content[31-8*(b*inst+j) -: 8];
      beat(inst, (b == 0), bd, crc);
      chk_mode = !chk;
    end
  endtask

  logic [31:0] ca, cb;
  logic [15:0] ka, kb;

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_m_valid", {47'd0, mv1}, 48'd0);
    check_eq("rst_m_dllp", dl1, 48'd0);
    check_eq("rst_s_ready", {47'd0, rdy1}, 48'd1);
    check_eq("rst_abort", {47'd0, ab1}, 48'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Beat without sop in IDLE is dropped
    beat(1, 1'b0, 32'h77, 16'h0);
    check_eq("drop_no_valid", {47'd0, mv1}, 48'd0);

    // 1: gen, all-zero content, latency one cycle after the 4th beat
    chk_mode = 1'b0;
    beat(1, 1'b1, 32'h0, 16'h0);
    beat(1, 1'b0, 32'h0, 16'h0);
    beat(1, 1'b0, 32'h0, 16'h0);
    check_eq("t1_not_yet", {47'd0, mv1}, 48'd0);
    beat(1, 1'b0, 32'h0, 16'h0);
    check_eq("t1_valid", {47'd0, mv1}, 48'd1);
    check_eq("t1_dllp", dl1, {32'h0, crc_model(32'h0)});
    check_eq("t1_err", {47'd0, er1}, 48'd0);

    // 2: loopback gen -> chk, then corrupt bit 0
    ca = 32'h0000_0001;
    ka = crc_model(ca);
    send_dllp(1, 1'b0, ca, 16'hDEAD);
    check_eq("t2_gen_dllp", dl1, {ca, ka});
    send_dllp(1, 1'b1, ca, ka);
    check_eq("t2_chk_err0", {47'd0, er1}, 48'd0);
    check_eq("t2_chk_dllp", dl1, {ca, ka});
    send_dllp(1, 1'b1, ca, ka ^ 16'h0001);
    check_eq("t2_chk_err1", {47'd0, er1}, 48'd1);

    // 3: same content on BPB = 1, 2, 4
    cb = 32'hA500_0F3C;
    kb = crc_model(cb);
    send_dllp(1, 1'b0, cb, 16'h0);
    check_eq("t3_bpb1", dl1, {cb, kb});
    send_dllp(2, 1'b0, cb, 16'h0);
    check_eq("t3_bpb2", dl2, {cb, kb});
    send_dllp(4, 1'b0, cb, 16'h0);
    check_eq("t3_bpb4", dl4, {cb, kb});
    send_dllp(2, 1'b1, cb, kb ^ 16'h8000);
    check_eq("t3_bpb2_chk_err", {47'd0, er2}, 48'd1);

    // 4: early sop after two bytes aborts the partial DLLP
    chk_mode = 1'b0;
    ca = 32'h1122_3344;
    beat(1, 1'b1, 32'hAA, 16'h0);
    beat(1, 1'b0, 32'hBB, 16'h0);
    check_eq("t4_no_abort_yet", {47'd0, ab1}, 48'd0);
    beat(1, 1'b1, 32'h11, 16'h0);
    check_eq("t4_abort", {47'd0, ab1}, 48'd1);
    beat(1, 1'b0, 32'h22, 16'h0);
    check_eq("t4_abort_pulse", {47'd0, ab1}, 48'd0);
    beat(1, 1'b0, 32'h33, 16'h0);
    beat(1, 1'b0, 32'h44, 16'h0);
    check_eq("t4_dllp", dl1, {ca, crc_model(ca)});

    // 5: back-pressure with a second DLLP waiting (BPB=4: each beat is a last beat)
    ca = 32'h0102_0304;
    cb = 32'hF0E0_D0C0;
    chk_mode = 1'b0;
    m_ready = 1'b0;
    v4 = 1'b1; sop4 = 1'b1; d4 = {ca[7:0], ca[15:8], ca[23:16], ca[31:24]};
    @(posedge clk); #1;
    check_eq("t5_first_valid", {47'd0, mv4}, 48'd1);
    d4 = {cb[7:0], cb[15:8], cb[23:16], cb[31:24]};
    for (int i = 0; i < 5; i++) begin
      check_eq("t5_stall_ready", {47'd0, rdy4}, 48'd0);
      check_eq("t5_hold_dllp", dl4, {ca, crc_model(ca)});
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    #1;
    check_eq("t5_ready_on_drain", {47'd0, rdy4}, 48'd1);
    @(posedge clk); #1;
    v4 = 1'b0; sop4 = 1'b0;
    check_eq("t5_no_bubble", {47'd0, mv4}, 48'd1);
    check_eq("t5_second_dllp", dl4, {cb, crc_model(cb)});
    @(posedge clk); #1;
    check_eq("t5_drained", {47'd0, mv4}, 48'd0);

    // 6: reset in the middle of a DLLP
    beat(1, 1'b1, 32'h5A, 16'h0);
    beat(1, 1'b0, 32'h6B, 16'h0);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_dllp", dl1, 48'd0);
    @(posedge clk); #1;
    check_eq("t6_rst_valid", {47'd0, mv1}, 48'd0);
    check_eq("t6_rst_err", {47'd0, er1}, 48'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ca = 32'hC0DE_1234;
    chk_mode = 1'b0;
    beat(1, 1'b1, 32'hC0, 16'h0);
    check_eq("t6_no_abort", {47'd0, ab1}, 48'd0);
    beat(1, 1'b0, 32'hDE, 16'h0);
    beat(1, 1'b0, 32'h12, 16'h0);
    beat(1, 1'b0, 32'h34, 16'h0);
    check_eq("t6_dllp", dl1, {ca, crc_model(ca)});

`ifdef DLLP_CRC_STATS_EN
    check_eq("t6_cnt_after_rst", {32'd0, ec1}, 48'd0);
    for (int i = 0; i < 3; i++) begin
      cb = 32'h1000_0000 + 32'(i);
      send_dllp(1, 1'b1, cb, crc_model(cb) ^ 16'h0100);
    end
    @(posedge clk); #1;
    check_eq("t6_err_cnt", {32'd0, ec1}, 48'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
